bsv_method_caller: RTL



---
 rtl/bsv_method_caller.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bsv_method_caller.sv
// Initiator for a BSV RDY/EN ActionValue method: request FIFO -> EN/arg pins, result -> response FIFO.
// Optional CALLER_STATS_EN adds saturating call_count / stall_count outputs.
module bsv_method_caller #(
   parameter int unsigned ARG_W     = 32,
   parameter int unsigned A_W       = 3,
   parameter int unsigned B_W       = 4,
   parameter int unsigned C_W       = 6,
   parameter int unsigned REQ_DEPTH = 2,
   parameter int unsigned RSP_DEPTH = 2
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   req_valid,
   input  logic [ARG_W-1:0]       req_arg,
   output logic                   req_ready,
   input  logic                   RDY_method,
   output logic                   EN_method,
   output logic [ARG_W-1:0]       method_in1,
   input  logic [A_W+B_W+C_W-1:0] method_res,
   output logic                   rsp_valid,
   output logic [A_W-1:0]         rsp_a,
   output logic [B_W-1:0]         rsp_b,
   output logic [C_W-1:0]         rsp_c,
   input  logic                   rsp_ready
`ifdef CALLER_STATS_EN
   ,
   output logic [15:0]            call_count,
   output logic [15:0]            stall_count
`endif
);

   localparam int unsigned REQ_AW = $clog2(REQ_DEPTH);
   localparam int unsigned REQ_CW = REQ_AW + 1;
   localparam int unsigned RSP_AW = $clog2(RSP_DEPTH);
   localparam int unsigned RSP_CW = RSP_AW + 1;

   typedef struct packed {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      logic [C_W-1:0] c;
   } res_t;

   logic [ARG_W-1:0]  r_req_mem [REQ_DEPTH];
   logic [REQ_AW-1:0] r_req_wr;
   logic [REQ_AW-1:0] r_req_rd;
   logic [REQ_CW-1:0] r_req_cnt;

   res_t              r_rsp_mem [RSP_DEPTH];
   logic [RSP_AW-1:0] r_rsp_wr;
   logic [RSP_AW-1:0] r_rsp_rd;
   logic [RSP_CW-1:0] r_rsp_cnt;
   res_t              r_rsp_hold;

   logic w_req_full;
   logic w_req_empty;
   logic w_req_push;
   logic w_rsp_full;
   logic w_rsp_nonempty;
   logic w_rsp_pop;
   logic w_rsp_space;
   logic w_call;
   res_t w_rsp_head;

   assign w_req_full     = (r_req_cnt == REQ_CW'(REQ_DEPTH));
   assign w_req_empty    = (r_req_cnt == '0);
   assign w_req_push     = req_valid & ~w_req_full;
   assign w_rsp_full     = (r_rsp_cnt == RSP_CW'(RSP_DEPTH));
   assign w_rsp_nonempty = (r_rsp_cnt != '0);
   assign w_rsp_pop      = w_rsp_nonempty & rsp_ready;
   assign w_rsp_space    = ~w_rsp_full | w_rsp_pop;
   // RST_N gate keeps EN low during the reset cycle even with requests still queued
   assign w_call         = RST_N & ~w_req_empty & RDY_method & w_rsp_space;

   assign req_ready  = ~w_req_full;
   assign EN_method  = w_call;
   assign method_in1 = r_req_mem[r_req_rd];
   assign rsp_valid  = w_rsp_nonempty;

   // Fields show the head entry, or the last shown value while the FIFO is empty
   always_comb begin
      w_rsp_head = r_rsp_hold;
      if (w_rsp_nonempty) begin
         w_rsp_head = r_rsp_mem[r_rsp_rd];
      end
   end

   assign rsp_a = w_rsp_head.a;
   assign rsp_b = w_rsp_head.b;
   assign rsp_c = w_rsp_head.c;

   // Storage arrays carry no reset; occupancy counters decide what is valid
   always_ff @(posedge CLK) begin
      if (w_req_push) begin
         r_req_mem[r_req_wr] <= req_arg;
      end
      if (w_call) begin
         r_rsp_mem[r_rsp_wr] <= res_t'(method_res);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_req_wr   <= '0;
         r_req_rd   <= '0;
         r_req_cnt  <= '0;
         r_rsp_wr   <= '0;
         r_rsp_rd   <= '0;
         r_rsp_cnt  <= '0;
         r_rsp_hold <= '0;
      end else begin
         if (w_req_push) begin
            r_req_wr <= r_req_wr + REQ_AW'(1);
         end
         if (w_call) begin
            r_req_rd <= r_req_rd + REQ_AW'(1);
            r_rsp_wr <= r_rsp_wr + RSP_AW'(1);
         end
         if (w_rsp_pop) begin
            r_rsp_rd <= r_rsp_rd + RSP_AW'(1);
         end
         r_req_cnt  <= r_req_cnt + REQ_CW'(w_req_push) - REQ_CW'(w_call);
         r_rsp_cnt  <= r_rsp_cnt + RSP_CW'(w_call) - RSP_CW'(w_rsp_pop);
         r_rsp_hold <= w_rsp_head;
      end
   end

`ifdef CALLER_STATS_EN
   logic [15:0] r_call_cnt;
   logic [15:0] r_stall_cnt;

   // Saturating event counters
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_call_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_call && (r_call_cnt != 16'hFFFF)) begin
            r_call_cnt <= r_call_cnt + 16'd1;
         end
         if (!w_req_empty && !w_call && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign call_count  = r_call_cnt;
   assign stall_count = r_stall_cnt;
`endif

   a_req_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
      !(w_req_push && w_req_full))
      else $error("request FIFO push while full");

   a_rsp_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
      !(w_call && w_rsp_full && !w_rsp_pop))
      else $error("response FIFO push while full");

endmodule
